lcd_hd44780_responder: RTL and testbench

//  Panel-side end of the HD44780 8-bit parallel bus (RS, RW, EN, DB[7:0]) driven by the LCD

---
 rtl/lcd_hd44780_responder.sv | 212 +++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: panel-side HD44780 8-bit bus model with a 2x16 DDRAM shadow,
// busy-time emulation, status/data readback and overrun detection.
`default_nettype none

module lcd_hd44780_responder #(
   parameter int BUSY_CYCLES  = 4625,
   parameter int CLEAR_CYCLES = 190000,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       SYS_clk,
   input  logic       SYS_reset,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_en,
   input  logic [7:0] lcd_db_in,
   output logic [7:0] lcd_db_out,
   output logic       lcd_db_oe,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic       busy,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       two_line,
   output logic       eight_bit,
   output logic       overrun,
   output logic       wr_strobe
);

   localparam int SW      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FILL, S_BUSY} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       fill_q, fill_d;
   logic             clear_q, clear_d;
   logic [6:0]       ac_q, ac_d;
   logic             id_q, id_d;
   logic             disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
   logic             two_line_q, two_line_d, eight_bit_q, eight_bit_d;
   logic             overrun_q, overrun_d, wr_strobe_q, wr_strobe_d;
   logic [7:0]       rd_char_q, rd_char_d;
   logic [7:0]       ram_q [32];
   logic [7:0]       ram_d [32];
   // {en, rs, rw, db}; the extra last stage holds the values seen while EN was still high
   logic [10:0]      sync_q [SW+1];
   logic [10:0]      sync_d [SW+1];

   logic       en_s, rs_s, rw_s, en_p, rs_p, rw_p, fall;
   logic [7:0] db_p, ac_data;
   logic       ac_vis;
   logic [4:0] ac_idx;

   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
      logic [6:0] r;
      if (inc) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      else     r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
      return r;
   endfunction

   assign en_s = sync_q[SW-1][10];
   assign rs_s = sync_q[SW-1][9];
   assign rw_s = sync_q[SW-1][8];
   assign en_p = sync_q[SW][10];
   assign rs_p = sync_q[SW][9];
   assign rw_p = sync_q[SW][8];
   assign db_p = sync_q[SW][7:0];
   assign fall = en_p & ~en_s;

   assign ac_vis  = (ac_q[5:4] == 2'b00);
   assign ac_idx  = {ac_q[6], ac_q[3:0]};
   assign ac_data = ac_vis ? ram_q[ac_idx] : 8'h20;

   // The expiry cycle already counts as not busy so a coincident write is accepted
   assign busy = (state_q != S_IDLE) && !(state_q == S_BUSY && cnt_q == '0);

   assign lcd_db_oe  = en_s & rw_s;
   assign lcd_db_out = lcd_db_oe ? (rs_s ? ac_data : {busy, ac_q}) : 8'h00;
   assign rd_char    = rd_char_q;
   assign disp_on    = disp_q;
   assign cursor_on  = cursor_q;
   assign blink_on   = blink_q;
   assign two_line   = two_line_q;
   assign eight_bit  = eight_bit_q;
   assign overrun    = overrun_q;
   assign wr_strobe  = wr_strobe_q;

   always_comb begin
      sync_d[0] = {lcd_en, lcd_rs, lcd_rw, lcd_db_in};
      for (int i = 1; i <= SW; i++) sync_d[i] = sync_q[i-1];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = (state_q != S_IDLE && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      fill_d      = fill_q;
      clear_d     = clear_q;
      ac_d        = ac_q;
      id_d        = id_q;
      disp_d      = disp_q;
      cursor_d    = cursor_q;
      blink_d     = blink_q;
      two_line_d  = two_line_q;
      eight_bit_d = eight_bit_q;
      overrun_d   = overrun_q;
      wr_strobe_d = 1'b0;
      rd_char_d   = ram_q[rd_addr];
      ram_d       = ram_q;

      case (state_q)
         S_EXEC: state_d = clear_q ? S_FILL : S_BUSY;
         S_FILL: begin
            ram_d[fill_q] = 8'h20;
            fill_d        = fill_q + 5'd1;
            if (fill_q == 5'd31) state_d = S_BUSY;
         end
         S_BUSY: if (cnt_q == '0) state_d = S_IDLE;
         default: ;
      endcase

      if (fall) begin
         if (!rw_p) begin
            if (busy) begin
               overrun_d = 1'b1;
            end else begin
               wr_strobe_d = 1'b1;
               state_d     = S_EXEC;
               cnt_d       = CNT_W'(BUSY_CYCLES);
               clear_d     = 1'b0;
               fill_d      = 5'd0;
               if (rs_p) begin
                  if (ac_vis) ram_d[ac_idx] = db_p;
                  ac_d = ac_step(ac_q, id_q);
               end else begin
                  casez (db_p)
                     8'b1???????: ac_d = db_p[6:0];
                     8'b01??????: ;
                     8'b001?????: begin
                        eight_bit_d = db_p[4];
                        two_line_d  = db_p[3];
                     end
                     8'b0001????: if (!db_p[3]) ac_d = ac_step(ac_q, db_p[2]);
                     8'b00001???: begin
                        disp_d   = db_p[2];
                        cursor_d = db_p[1];
                        blink_d  = db_p[0];
                     end
                     8'b000001??: id_d = db_p[1];
                     8'b0000001?: begin
                        ac_d  = 7'h00;
                        cnt_d = CNT_W'(CLEAR_CYCLES);
                     end
                     8'b00000001: begin
                        ac_d    = 7'h00;
                        id_d    = 1'b1;
                        clear_d = 1'b1;
                        cnt_d   = CNT_W'(CLEAR_CYCLES);
                     end
                     default: ;
                  endcase
               end
            end
         end else if (rs_p && !busy) begin
            ac_d = ac_step(ac_q, id_q);
         end
      end
   end

   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         fill_q      <= 5'd0;
         clear_q     <= 1'b0;
         ac_q        <= 7'h00;
         id_q        <= 1'b1;
         disp_q      <= 1'b0;
         cursor_q    <= 1'b0;
         blink_q     <= 1'b0;
         two_line_q  <= 1'b0;
         eight_bit_q <= 1'b1;
         overrun_q   <= 1'b0;
         wr_strobe_q <= 1'b0;
         rd_char_q   <= 8'h20;
         for (int i = 0; i < 32; i++) ram_q[i] <= 8'h20;
         for (int i = 0; i <= SW; i++) sync_q[i] <= 11'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fill_q      <= fill_d;
         clear_q     <= clear_d;
         ac_q        <= ac_d;
         id_q        <= id_d;
         disp_q      <= disp_d;
         cursor_q    <= cursor_d;
         blink_q     <= blink_d;
         two_line_q  <= two_line_d;
         eight_bit_q <= eight_bit_d;
         overrun_q   <= overrun_d;
         wr_strobe_q <= wr_strobe_d;
         rd_char_q   <= rd_char_d;
         for (int i = 0; i < 32; i++) ram_q[i] <= ram_d[i];
         for (int i = 0; i <= SW; i++) sync_q[i] <= sync_d[i];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder with shortened busy timings.
`default_nettype none

module tb_lcd_hd44780_responder;
   localparam int BC = 20;
   localparam int CC = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
   logic [7:0] lcd_db_in = 8'h00;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] lcd_db_out, rd_char;
   logic       lcd_db_oe, busy, disp_on, cursor_on, blink_on, two_line, eight_bit;
   logic       overrun, wr_strobe;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   lcd_hd44780_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC), .SYNC_STAGES(2)) dut (
      .SYS_clk(clk), .SYS_reset(rst_n),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_db_in(lcd_db_in),
      .lcd_db_out(lcd_db_out), .lcd_db_oe(lcd_db_oe),
      .rd_addr(rd_addr), .rd_char(rd_char), .busy(busy),
      .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .two_line(two_line), .eight_bit(eight_bit),
      .overrun(overrun), .wr_strobe(wr_strobe)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic strobe(input logic rs, input logic rw, input logic [7:0] db);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_db_in = db;
      @(negedge clk);
      lcd_en = 1'b1;
      repeat (4) @(negedge clk);
      lcd_en = 1'b0;
   endtask

   task automatic wr_nowait(input logic rs, input logic [7:0] db, input string tag);
      int n;
      strobe(rs, 1'b0, db);
      n = 0;
      while (wr_strobe !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check(tag, wr_strobe, 1);
   endtask

   task automatic wr(input logic rs, input logic [7:0] db, input string tag, output int blen);
      wr_nowait(rs, db, tag);
      blen = 0;
      while (busy === 1'b1 && blen < 1000) begin
         blen++;
         @(negedge clk);
      end
   endtask

   task automatic rd_bus(input logic rs, output logic [7:0] data, output logic oe);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = 1'b1;
      @(negedge clk);
      lcd_en = 1'b1;
      repeat (4) @(negedge clk);
      data = lcd_db_out;
      oe = lcd_db_oe;
      lcd_en = 1'b0;
      repeat (4) @(negedge clk);
      lcd_rw = 1'b0;
   endtask

   task automatic rdchk(input logic [4:0] a, input logic [7:0] exp, input string tag);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      check(tag, rd_char, exp);
   endtask

   task automatic status(input logic [7:0] exp, input string tag);
      logic [7:0] d;
      logic oe;
      rd_bus(1'b0, d, oe);
      check(tag, {oe, d}, {1'b1, exp});
   endtask

   initial begin
      int bl;
      int n;
      logic seen;
      logic [7:0] d;
      logic oe;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_modes", {eight_bit, two_line, disp_on, cursor_on, blink_on}, 5'b10000);
      check("rst_flags", {overrun, wr_strobe, lcd_db_oe}, 3'b000);
      check("rst_dbout", lcd_db_out, 8'h00);
      check("rst_rdchar", rd_char, 8'h20);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) rdchk(5'(i), 8'h20, "blank_after_reset");

      // function set / display / entry mode, busy exactly BC cycles
      wr(1'b0, 8'h38, "fs_strobe", bl);
      check("fs_busy_len", bl, BC);
      wr(1'b0, 8'h0C, "disp_strobe", bl);
      check("disp_busy_len", bl, BC);
      wr(1'b0, 8'h06, "entry_strobe", bl);
      check("entry_busy_len", bl, BC);
      check("modes_init", {eight_bit, two_line, disp_on, cursor_on, blink_on}, 5'b11100);

      // line 1 data and status read
      wr(1'b0, 8'h80, "ddram0", bl);
      wr(1'b1, 8'h48, "data_H", bl);
      wr(1'b1, 8'h49, "data_I", bl);
      rdchk(5'd0, 8'h48, "rd_char0_H");
      rdchk(5'd1, 8'h49, "rd_char1_I");
      status(8'h02, "status_ac2");
      check("oe_released", {lcd_db_oe, lcd_db_out}, 9'h000);

      // invisible address, wrap to line 2, decrement wrap
      wr(1'b0, 8'hA7, "ddram27", bl);
      wr(1'b1, 8'h58, "data_X", bl);
      status(8'h40, "status_wrap40");
      wr(1'b1, 8'h59, "data_Y", bl);
      rdchk(5'd16, 8'h59, "rd_char16_Y");
      status(8'h41, "status_ac41");
      wr(1'b0, 8'hC0, "ddram40", bl);
      wr(1'b0, 8'h04, "entry_dec", bl);
      wr(1'b1, 8'h5A, "data_Z", bl);
      status(8'h27, "status_dec27");
      rdchk(5'd16, 8'h5A, "rd_char16_Z");

      // data read with decrement wrap 0x00 -> 0x67
      wr(1'b0, 8'h80, "ddram0_b", bl);
      rd_bus(1'b1, d, oe);
      check("data_read0", {oe, d}, {1'b1, 8'h48});
      status(8'h67, "status_dec67");
      wr(1'b0, 8'h06, "entry_inc", bl);

      // return home: long busy, AC back to 0
      wr(1'b0, 8'h02, "home_strobe", bl);
      check("home_busy_len", bl, CC);
      status(8'h00, "status_home");

      // clear display with an overrun during the clear
      wr_nowait(1'b0, 8'h01, "clear_strobe");
      repeat (10) @(negedge clk);
      status(8'h80, "status_clearing");
      strobe(1'b1, 1'b0, 8'h41);
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (wr_strobe === 1'b1) seen = 1'b1;
      end
      check("overrun_write_ignored", seen, 0);
      check("overrun_set", overrun, 1);
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("clear_done", busy, 0);
      for (int i = 0; i < 32; i++) rdchk(5'(i), 8'h20, "blank_after_clear");
      status(8'h00, "status_after_clear");
      check("overrun_sticky", overrun, 1);

      // reset in the middle of a clear fill
      wr(1'b1, 8'h41, "data_A", bl);
      rdchk(5'd0, 8'h41, "rd_char0_A");
      wr_nowait(1'b0, 8'h01, "clear2_strobe");
      repeat (5) @(negedge clk);
      check("mid_fill_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("reset_busy_now", busy, 0);
      @(negedge clk);
      check("reset_overrun", overrun, 0);
      check("reset_modes", {eight_bit, two_line, disp_on}, 3'b100);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) rdchk(5'(i), 8'h20, "blank_after_midfill_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
